// File: rtl/div32_seq_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential 32-bit divider slice: data and
// iteration-counter widths, the FSM state type, the quotient reported on
// a zero divisor, and the two's complement negator used by the datapath.
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int DATA_W = 32;
  localparam int ITER_W = 6;

  // A zero divisor reports an all-ones quotient.
  localparam logic [DATA_W-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIV,
    FIX,
    DONE
  } state_t;

  // Two's complement negation, written as ~x + 1 so that it maps onto a
  // single incrementer behind an inverter.
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    return ~x + DATA_W'(1);
  endfunction

endpackage

// File: rtl/div32_seq_if.sv
// ---------------------------------------------------------------------------
// div32_seq_if
// Request/result bundle between a requester (master) and the divider
// (slave).
//   start       : request pulse, only looked at while the divider is idle
//   sign        : 1 = signed two's complement divide, 0 = unsigned
//   dividend    : numerator, captured with start
//   divisor     : denominator, captured with start
//   busy        : divider working on an accepted request
//   done        : one-cycle pulse, results valid in that cycle
//   quotient    : result, held until the next accepted start
//   remainder   : result, held until the next accepted start
//   div_by_zero : set when the captured divisor was zero
// ---------------------------------------------------------------------------
interface div32_seq_if;
  import div_pkg::*;

  logic              start;
  logic              sign;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_by_zero;

  modport master (
    output start, sign, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, sign, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div32_seq_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   i_partRem : 33-bit partial remainder before the iteration
//   i_quo     : quotient/dividend shift register before the iteration
//   i_divMag  : divisor magnitude
//   o_partRem : partial remainder after the iteration
//   o_quo     : shift register after the iteration (new quotient bit in LSB)
// ---------------------------------------------------------------------------
module div_step
  import div_pkg::*;
(
  input  logic [DATA_W:0]   i_partRem,
  input  logic [DATA_W-1:0] i_quo,
  input  logic [DATA_W-1:0] i_divMag,
  output logic [DATA_W:0]   o_partRem,
  output logic [DATA_W-1:0] o_quo
);

  logic [DATA_W+1:0] w_shifted;
  logic [DATA_W+1:0] w_diff;

  // {rem,quo} shifted left by one: the next dividend bit enters the
  // remainder. One guard bit above the remainder keeps the trial
  // subtraction's sign bit separate from the value.
  assign w_shifted = {i_partRem, i_quo[DATA_W-1]};
  assign w_diff    = w_shifted - {2'b00, i_divMag};

  // Commit the subtraction only when it did not go negative; otherwise
  // the shifted remainder is restored and the new quotient bit stays 0.
  always_comb begin
    o_partRem = w_shifted[DATA_W:0];
    o_quo     = {i_quo[DATA_W-2:0], 1'b0};
    if (!w_diff[DATA_W+1]) begin
      o_partRem = w_diff[DATA_W:0];
      o_quo[0]  = 1'b1;
    end
  end

endmodule

// File: rtl/div32_seq.sv
// ---------------------------------------------------------------------------
// div32_seq
// Sequential 32-bit signed/unsigned restoring divider with a fixed
// 35-cycle latency from accepted start to done.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, wins over start
//   bus : div32_seq_if slave modport (start/sign/operands in,
//         busy/done/quotient/remainder/div_by_zero out)
// Flow: IDLE -> PREP (magnitudes, result signs) -> DIV (32 iterations)
//       -> FIX (sign correction, results latched) -> DONE (done pulse).
// ---------------------------------------------------------------------------
module div32_seq
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  div32_seq_if.slave  bus
);

  state_t r_state;
  state_t w_nextState;

  logic              r_sign;
  logic [DATA_W-1:0] r_dividend;
  logic [DATA_W-1:0] r_divisor;
  logic [DATA_W:0]   r_partRem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_divMag;
  logic [ITER_W-1:0] r_iter;
  logic              r_quoNeg;
  logic              r_remNeg;
  logic              r_dbz;
  logic [DATA_W-1:0] r_quotient;
  logic [DATA_W-1:0] r_remainder;
  logic              r_divByZero;

  logic [DATA_W-1:0] w_negInA;
  logic [DATA_W-1:0] w_negInB;
  logic [DATA_W-1:0] w_negA;
  logic [DATA_W-1:0] w_negB;
  logic [DATA_W:0]   w_stepRem;
  logic [DATA_W-1:0] w_stepQuo;
  logic              w_unusedRemMsb;

  // The partial remainder never exceeds the divisor magnitude, so its
  // guard bit is always zero once the iterations are finished.
  assign w_unusedRemMsb = r_partRem[DATA_W];

  // One negator pair serves both PREP (operand magnitudes) and FIX
  // (result sign correction); the state picks what gets negated.
  assign w_negInA = (r_state == PREP) ? r_dividend : r_quo;
  assign w_negInB = (r_state == PREP) ? r_divisor  : r_partRem[DATA_W-1:0];
  assign w_negA   = negate(w_negInA);
  assign w_negB   = negate(w_negInB);

  div_step u_step (
    .i_partRem (r_partRem),
    .i_quo     (r_quo),
    .i_divMag  (r_divMag),
    .o_partRem (w_stepRem),
    .o_quo     (w_stepQuo)
  );

  // State register; reset returns to IDLE and wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. The DIV exit sits on the last counter value so the
  // latency is the same for every operand, including a zero divisor.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (bus.start) w_nextState = PREP;
      PREP: w_nextState = DIV;
      DIV:  if (r_iter == ITER_W'(DATA_W - 1)) w_nextState = FIX;
      FIX:  w_nextState = DONE;
      DONE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath. Operands are captured only when a start is accepted; the
  // visible result registers change only in FIX, so they hold through the
  // whole of the next operation until its own results are ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign      <= 1'b0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_partRem   <= '0;
      r_quo       <= '0;
      r_divMag    <= '0;
      r_iter      <= '0;
      r_quoNeg    <= 1'b0;
      r_remNeg    <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divByZero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sign     <= bus.sign;
            r_dividend <= bus.dividend;
            r_divisor  <= bus.divisor;
          end
        end
        PREP: begin
          r_quo     <= (r_sign && r_dividend[DATA_W-1]) ? w_negA : r_dividend;
          r_divMag  <= (r_sign && r_divisor[DATA_W-1])  ? w_negB : r_divisor;
          r_partRem <= '0;
          r_iter    <= '0;
          r_quoNeg  <= r_sign & (r_dividend[DATA_W-1] ^ r_divisor[DATA_W-1]);
          r_remNeg  <= r_sign & r_dividend[DATA_W-1];
          r_dbz     <= (r_divisor == '0);
        end
        DIV: begin
          r_partRem <= w_stepRem;
          r_quo     <= w_stepQuo;
          r_iter    <= r_iter + ITER_W'(1);
        end
        FIX: begin
          // A zero divisor reports the untouched dividend as remainder and
          // skips sign correction entirely. The signed overflow case needs
          // no special handling: |0x80000000| / 1 already gives 0x80000000
          // and both operand signs are negative, so no negation happens.
          if (r_dbz) begin
            r_quotient  <= DBZ_QUOTIENT;
            r_remainder <= r_dividend;
            r_divByZero <= 1'b1;
          end else begin
            r_quotient  <= r_quoNeg ? w_negA : r_quo;
            r_remainder <= r_remNeg ? w_negB : r_partRem[DATA_W-1:0];
            r_divByZero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy        = (r_state == PREP) || (r_state == DIV) || (r_state == FIX);
  assign bus.done        = (r_state == DONE);
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_divByZero;

endmodule

// File: tb/tb_div32_seq.sv
// ---------------------------------------------------------------------------
// tb_div32_seq
// Self-checking bench for div32_seq: a table of hand-computed vectors,
// hand-written control sequences (start while busy / during done, reset
// mid-operation) and a short batch of random operands against a
// behavioural reference.
// ---------------------------------------------------------------------------
module tb_div32_seq;
  import div_pkg::*;

  typedef struct packed {
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] expQuo;
    logic [31:0] expRem;
    logic        expDbz;
  } vec_t;

  localparam int NUM_VECS = 16;
  localparam int NUM_RAND = 200;

  logic clk;
  logic rst;
  int   numVectors;
  int   numMiss;
  vec_t vecs [NUM_VECS];

  div32_seq_if bus ();

  div32_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a miscompare.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    numVectors++;
    if (actual !== expected) begin
      numMiss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issue one request at a negedge (accepted at the following posedge N)
  // and follow it to done. latency is the cycle index after N in which
  // done was seen (0 if it never came); busyOk clears if busy was low in
  // any cycle before done or high in the done cycle.
  task automatic applyStimulus(input logic s, input logic [31:0] a,
                               input logic [31:0] b, output int latency,
                               output bit busyOk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.sign     = s;
    bus.dividend = a;
    bus.divisor  = b;
    latency = 0;
    busyOk  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start    = 1'b0;
        bus.sign     = 1'($urandom_range(0, 1));
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
      end
      if (bus.done) begin
        latency = c;
        if (bus.busy) busyOk = 1'b0;
        break;
      end
      if (!bus.busy) busyOk = 1'b0;
    end
  endtask

  // Behavioural reference: the language's own truncating divide.
  task automatic refDiv(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dbz);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    dbz = 1'b0;
    if (b == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      dbz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  initial begin
    int          lat;
    bit          bOk;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;

    numVectors = 0;
    numMiss    = 0;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0};
    vecs[2]  = '{1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0};
    vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
    vecs[4]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0};
    vecs[5]  = '{1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1};
    vecs[6]  = '{1'b0, 32'h12345678,  32'd0,         32'hFFFFFFFF,  32'h12345678,  1'b1};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0};
    vecs[9]  = '{1'b0, 32'd7,         32'd100,       32'd0,         32'd7,         1'b0};
    vecs[10] = '{1'b1, 32'hFFFFFFF9,  32'd100,       32'd0,         32'hFFFFFFF9,  1'b0};
    vecs[11] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0};
    vecs[12] = '{1'b1, 32'h80000000,  32'd1,         32'h80000000,  32'd0,         1'b0};
    vecs[13] = '{1'b1, 32'h80000000,  32'd2,         32'hC0000000,  32'd0,         1'b0};
    vecs[14] = '{1'b0, 32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
    vecs[15] = '{1'b0, 32'hDEADBEEF,  32'h10,        32'h0DEADBEE,  32'hF,         1'b0};

    bus.start    = 1'b0;
    bus.sign     = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst          = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset busy",      32'(bus.busy),        32'd0);
    checkOutput("reset done",      32'(bus.done),        32'd0);
    checkOutput("reset quotient",  bus.quotient,         32'd0);
    checkOutput("reset remainder", bus.remainder,        32'd0);
    checkOutput("reset dbz",       32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].sign, vecs[i].dividend, vecs[i].divisor, lat, bOk);
      $display("[TB] vector %0d: sign=%0b %h / %h", i, vecs[i].sign,
               vecs[i].dividend, vecs[i].divisor);
      checkOutput("latency",   32'(lat),             32'd35);
      checkOutput("busy",      32'(bOk),             32'd1);
      checkOutput("quotient",  bus.quotient,         vecs[i].expQuo);
      checkOutput("remainder", bus.remainder,        vecs[i].expRem);
      checkOutput("dbz",       32'(bus.div_by_zero), 32'(vecs[i].expDbz));
    end

    // start pulsed while busy and in the done cycle must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = (c == 5);
      if (c == 5) begin
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
      end
      if (bus.done) begin
        lat = c;
        bus.start    = 1'b1;
        bus.dividend = 32'd999;
        bus.divisor  = 32'd4;
        break;
      end
    end
    checkOutput("ctl latency", 32'(lat), 32'd35);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("ctl busy after done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("ctl idle after done", 32'(bus.busy), 32'd0);
    checkOutput("ctl quotient",  bus.quotient,  32'd14);
    checkOutput("ctl remainder", bus.remainder, 32'd2);

    // Reset at cycle N+10 aborts; a start right after reset is accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b1; bus.dividend = 32'hFFFFFF9C; bus.divisor = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort busy",      32'(bus.busy),        32'd0);
    checkOutput("abort done",      32'(bus.done),        32'd0);
    checkOutput("abort quotient",  bus.quotient,         32'd0);
    checkOutput("abort remainder", bus.remainder,        32'd0);
    checkOutput("abort dbz",       32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;
    bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    checkOutput("post-reset latency",   32'(lat),      32'd35);
    checkOutput("post-reset quotient",  bus.quotient,  32'd333);
    checkOutput("post-reset remainder", bus.remainder, 32'd1);

    // Random operands against the behavioural reference.
    for (int i = 0; i < NUM_RAND; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i % 25 == 0) b = 32'd0;
      refDiv(s, a, b, q, r, dbz);
      applyStimulus(s, a, b, lat, bOk);
      checkOutput("rand latency",   32'(lat),             32'd35);
      checkOutput("rand quotient",  bus.quotient,         q);
      checkOutput("rand remainder", bus.remainder,        r);
      checkOutput("rand dbz",       32'(bus.div_by_zero), 32'(dbz));
      checkOutput("rand identity",  bus.quotient * b + bus.remainder, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiss);
    $finish;
  end

endmodule
